// File: rtl/dht11_responder.sv
// dht11_responder: emulates the sensor side of a DHT11 single-wire bus.
// It waits for a host start pulse (line low for at least START_MIN_TICKS),
// then answers with an 80/80 us response pulse and a 40-bit frame:
// hum_int, hum_dec, tmp_int, tmp_dec, checksum (MSB first).
// All protocol timing counts the 10 us tick pulse only.
//
// Optional build macro DHT11_CHKSUM_ERR_EN adds err_inject. When the frame
// is latched and err_inject is 1, the checksum LSB is inverted.
//
// Ports:
//   clk        in    system clock (100 MHz)
//   rst        in    synchronous active-high reset
//   tick       in    one-clk pulse every 10 us
//   dht_io     inout open-drain bus: driven 0 or released, never driven 1
//   hum_int/hum_dec/tmp_int/tmp_dec  in [7:0]  sensor bytes to send
//   err_inject in    (DHT11_CHKSUM_ERR_EN only) corrupt the checksum LSB
//   busy       out   high from RSP_DLY through END_LOW
//   done       out   one-clk pulse when a frame completes
//   frame_cnt  out   [7:0] completed-frame count, wraps
module dht11_responder #(
    parameter int START_MIN_TICKS = 1800,
    parameter int RSP_DLY_TICKS   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    inout  wire        dht_io,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] tmp_int,
    input  logic [7:0] tmp_dec,
`ifdef DHT11_CHKSUM_ERR_EN
    input  logic       err_inject,
`endif
    output logic       busy,
    output logic       done,
    output logic [7:0] frame_cnt
);

    // Counter must hold the saturated host-low count and the 8-tick phases.
    localparam int CW = ($clog2(START_MIN_TICKS + 1) > 4) ? $clog2(START_MIN_TICKS + 1) : 4;

    localparam logic [CW-1:0] START_MIN  = CW'(START_MIN_TICKS);
    localparam logic [CW-1:0] DLY_LAST   = CW'(RSP_DLY_TICKS - 1);
    localparam logic [CW-1:0] PHASE_LAST = CW'(7);  // 8-tick response phases
    localparam logic [CW-1:0] LOW_LAST   = CW'(4);  // 5-tick low pulses
    localparam logic [CW-1:0] ZERO_LAST  = CW'(2);  // 3-tick high = bit 0
    localparam logic [CW-1:0] ONE_LAST   = CW'(6);  // 7-tick high = bit 1

    typedef enum logic [2:0] {
        IDLE, HOST_LOW, RSP_DLY, RSP_LOW, RSP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    bit_q, bit_d;
    logic [39:0]   sr_q, sr_d;
    logic [7:0]    frame_q, frame_d;
    logic          done_q, done_d;
    logic          drive_low_q, drive_low_d;
    logic          armed_q, armed_d;
    logic          sync1_q, line_q;
    logic          err;
    logic [7:0]    chk;
    logic [CW-1:0] hi_last;

`ifdef DHT11_CHKSUM_ERR_EN
    assign err = err_inject;
`else
    assign err = 1'b0;
`endif

    assign chk = hum_int + hum_dec + tmp_int + tmp_dec;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        // Re-arm only once the line has been seen high, so our own END_LOW
        // pulse is never mistaken for a host start.
        armed_d = armed_q | line_q;
        hi_last = sr_q[39] ? ONE_LAST : ZERO_LAST;

        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!line_q && armed_q) begin
                        state_d = HOST_LOW;
                        cnt_d   = '0;
                    end
                end
                HOST_LOW: begin
                    if (line_q) begin
                        if (cnt_q >= START_MIN) begin
                            state_d = RSP_DLY;
                            cnt_d   = '0;
                            bit_d   = '0;
                            sr_d    = {hum_int, hum_dec, tmp_int, tmp_dec,
                                       chk ^ {7'd0, err}};
                        end else begin
                            state_d = IDLE;  // too short: glitch, no reply
                        end
                    end else if (cnt_q != START_MIN) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RSP_DLY: begin
                    if (cnt_q == DLY_LAST) begin state_d = RSP_LOW; cnt_d = '0; end
                    else cnt_d = cnt_q + 1'b1;
                end
                RSP_LOW: begin
                    if (cnt_q == PHASE_LAST) begin state_d = RSP_HIGH; cnt_d = '0; end
                    else cnt_d = cnt_q + 1'b1;
                end
                RSP_HIGH: begin
                    if (cnt_q == PHASE_LAST) begin state_d = BIT_LOW; cnt_d = '0; end
                    else cnt_d = cnt_q + 1'b1;
                end
                BIT_LOW: begin
                    if (cnt_q == LOW_LAST) begin state_d = BIT_HIGH; cnt_d = '0; end
                    else cnt_d = cnt_q + 1'b1;
                end
                BIT_HIGH: begin
                    if (cnt_q == hi_last) begin
                        cnt_d   = '0;
                        sr_d    = {sr_q[38:0], 1'b0};
                        bit_d   = bit_q + 6'd1;
                        state_d = (bit_q == 6'd39) ? END_LOW : BIT_LOW;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                END_LOW: begin
                    if (cnt_q == LOW_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        frame_d = frame_q + 8'd1;
                        armed_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Drive flag follows the next state so the bus changes with the state.
        drive_low_d = (state_d == RSP_LOW) || (state_d == BIT_LOW) || (state_d == END_LOW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            line_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            sr_q        <= '0;
            frame_q     <= '0;
            done_q      <= 1'b0;
            drive_low_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sync1_q     <= dht_io;
            line_q      <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sr_q        <= sr_d;
            frame_q     <= frame_d;
            done_q      <= done_d;
            drive_low_q <= drive_low_d;
            armed_q     <= armed_d;
        end
    end

    assign dht_io    = drive_low_q ? 1'b0 : 1'bz;
    assign busy      = (state_q != IDLE) && (state_q != HOST_LOW);
    assign done      = done_q;
    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: host start pulses go out, expected frames are
// queued from a byte-level model, and a wire monitor decodes the bus
// waveform and compares it with the queue.
module tb_dht11_responder;
    localparam int TP = 3;  // clocks per tick

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       host_low = 1'b0;
    logic [7:0] hum_int = '0, hum_dec = '0, tmp_int = '0, tmp_dec = '0;
    logic       busy, done;
    logic [7:0] frame_cnt;
`ifdef DHT11_CHKSUM_ERR_EN
    logic       err_inject = 1'b0;
`endif

    wire dht_bus;
    pullup (dht_bus);
    assign dht_bus = host_low ? 1'b0 : 1'bz;

    dht11_responder dut (
        .clk(clk), .rst(rst), .tick(tick), .dht_io(dht_bus),
        .hum_int(hum_int), .hum_dec(hum_dec), .tmp_int(tmp_int), .tmp_dec(tmp_dec),
`ifdef DHT11_CHKSUM_ERR_EN
        .err_inject(err_inject),
`endif
        .busy(busy), .done(done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [39:0] exp_q[$];
    bit mon_ab;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Reference frame: four bytes, then their sum mod 256 (LSB flipped on err).
    function automatic logic [39:0] model_frame(input logic [7:0] a, b, c, d, input logic e);
        int s;
        s = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
        if (e) s = s ^ 1;
        return {a, b, c, d, 8'(s)};
    endfunction

    // Tick generator: one-clk pulse every TP clocks.
    initial begin
        int tc;
        tc = 0;
        forever begin
            @(negedge clk);
            tc = (tc + 1) % TP;
            tick = (tc == 0);
        end
    end

    // Done checker: frame_cnt tracks completed frames, done is one clk wide,
    // and the bus is released in the same cycle.
    initial begin
        logic [7:0] exp_fc;
        int run;
        exp_fc = '0;
        run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_fc = '0;
                run = 0;
            end else if (done) begin
                run++;
                if (run == 1) begin
                    exp_fc = exp_fc + 8'd1;
                    done_cnt++;
                    chk("done_frame_cnt", frame_cnt, exp_fc);
                    chk("done_bus_released", dht_bus, 1);
                end
            end else begin
                if (run > 0) chk("done_width", run, 1);
                run = 0;
            end
        end
    end

    // Length in clocks of the current bus level, starting at this sample.
    task automatic meas(input logic lvl, output int len);
        len = 0;
        do begin
            len++;
            @(negedge clk);
            if (rst) begin mon_ab = 1'b1; return; end
        end while (dht_bus === lvl && len < 200);
    endtask

    task automatic mon_frame();
        int len;
        logic [39:0] got, exp;
        mon_ab = 1'b0;
        got = '0;
        chk("frame_expected", exp_q.size() > 0, 1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 40'd0;
        meas(1'b0, len); if (mon_ab) return;
        chk("rsp_low_len", len, 8 * TP);
        meas(1'b1, len); if (mon_ab) return;
        chk("rsp_high_len", len, 8 * TP);
        for (int i = 0; i < 40; i++) begin
            meas(1'b0, len); if (mon_ab) return;
            chk("bit_low_len", len, 5 * TP);
            meas(1'b1, len); if (mon_ab) return;
            got[39-i] = (len > 5 * TP);
            chk("bit_high_len", len, exp[39-i] ? 7 * TP : 3 * TP);
        end
        meas(1'b0, len); if (mon_ab) return;
        chk("end_low_len", len, 5 * TP);
        chk("frame_data", got, exp);
    endtask

    // Wire monitor: a low the host is not causing starts a responder frame.
    initial begin
        logic hprev;
        hprev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && dht_bus === 1'b0 && !host_low && !hprev) mon_frame();
            hprev = host_low;
        end
    end

    task automatic set_bytes(input logic [7:0] a, b, c, d);
        hum_int = a; hum_dec = b; tmp_int = c; tmp_dec = d;
    endtask

    // One host start (18.1 ms low) plus the expected reply. chg_bit >= 0
    // zeroes the inputs at that bit; rst_bit >= 0 resets during that BIT_LOW.
    task automatic run_frame(input logic [7:0] a, b, c, d, input logic e,
                             input int chg_bit, input int rst_bit);
        int n, edges, target, d0;
        logic prev, ee;
        ee = 1'b0;
        set_bytes(a, b, c, d);
`ifdef DHT11_CHKSUM_ERR_EN
        err_inject = e;
        ee = e;
`endif
        exp_q.push_back(model_frame(a, b, c, d, ee));
        d0 = done_cnt;
        host_low = 1'b1;
        repeat (1810 * TP) @(negedge clk);
        host_low = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (dht_bus !== 1'b0 && n < 40 * TP);
        chk("rsp_gap_ok", (n >= 3 * TP + 3 && n <= 4 * TP + 2), 1);
        if (chg_bit < 0 && rst_bit < 0) begin
            set_bytes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
`ifdef DHT11_CHKSUM_ERR_EN
            err_inject = ~e;
`endif
        end else begin
            target = ((chg_bit >= 0) ? chg_bit : rst_bit) + 2;
            edges = 1; prev = 1'b0; n = 0;
            while (edges < target && n < 2000 * TP) begin
                @(negedge clk);
                n++;
                if (prev === 1'b1 && dht_bus === 1'b0) edges++;
                prev = dht_bus;
            end
            chk("bit_edge_found", edges, target);
            if (chg_bit >= 0) begin
                set_bytes(8'h00, 8'h00, 8'h00, 8'h00);
            end else begin
                rst = 1'b1;
                @(negedge clk);
                chk("rst_bus_released", dht_bus, 1);
                chk("rst_busy_low", busy, 0);
                repeat (2) @(negedge clk);
                rst = 1'b0;
                repeat (20 * TP) @(negedge clk);
                chk("rst_no_done", done_cnt, d0);
                chk("rst_frame_cnt", frame_cnt, 0);
                return;
            end
        end
        n = 0;
        while (done_cnt == d0 && n < 1000 * TP) begin @(negedge clk); n++; end
        chk("frame_done", done_cnt, d0 + 1);
        repeat (4 * TP) @(negedge clk);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout, want end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, bad_busy, bad_bus;
        repeat (4) @(negedge clk);
        chk("reset_bus", dht_bus, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_frame_cnt", frame_cnt, 0);
        rst = 1'b0;
        repeat (4 * TP) @(negedge clk);

        // Reference frame 37 00 18 05 -> checksum 54.
        run_frame(8'h37, 8'h00, 8'h18, 8'h05, 1'b0, -1, -1);
        chk("t1_frame_cnt", frame_cnt, 1);

        // 10 ms host low is rejected: no drive, no busy, no done.
        d0 = done_cnt; bad_busy = 0; bad_bus = 0;
        host_low = 1'b1;
        for (int i = 0; i < 1000 * TP; i++) begin @(negedge clk); if (busy) bad_busy++; end
        host_low = 1'b0;
        for (int i = 0; i < 100 * TP; i++) begin
            @(negedge clk);
            if (busy) bad_busy++;
            if (dht_bus !== 1'b1) bad_bus++;
        end
        chk("glitch_busy", bad_busy, 0);
        chk("glitch_bus", bad_bus, 0);
        chk("glitch_done", done_cnt, d0);

        // Checksum wrap: FF*4 -> FC.
        run_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, -1, -1);
        // Inputs zeroed at bit 10: frame keeps the latched bytes.
        run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 10, -1);
        // Reset during bit 20, then a clean frame.
        run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, -1, 20);
        run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, -1, -1);
        chk("post_rst_frame_cnt", frame_cnt, 1);
        run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), -1, -1);
`ifdef DHT11_CHKSUM_ERR_EN
        run_frame(8'h37, 8'h00, 8'h18, 8'h05, 1'b1, -1, -1);
`endif
        chk("exp_queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
